// File: rtl/tcb_lib_pkg.sv
// Shared TCB library types: response status, memory wait-state encoding
// and helpers common to subordinates and register slices.
package tcb_lib_pkg;

    typedef enum logic {
        TCB_OK  = 1'b0,
        TCB_ERR = 1'b1
    } tcb_sts_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } tcb_mem_st_t;

    localparam int unsigned TCB_DLY_MIN = 1;
    localparam int unsigned TCB_DLY_MAX = 4;

    function automatic int unsigned tcb_ben_w(input int unsigned dat_w);
        return dat_w / 8;
    endfunction

endpackage

// File: rtl/tcb_lib_memory_delay.sv
// Response pipeline for the TCB memory: DLY-1 register stages carrying
// {transfer, read enables, data, error}; the top's output registers finish it.
module tcb_lib_memory_delay
    import tcb_lib_pkg::*;
#(
    parameter int unsigned DLY   = 2,
    parameter int unsigned DAT_W = 32,
    parameter int unsigned BEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_trn,
    input  logic [BEN_W-1:0] req_ren,
    input  logic [DAT_W-1:0] req_dat,
    input  logic             req_err,
    output logic             rsp_trn,
    output logic [BEN_W-1:0] rsp_ren,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err
);

    localparam int unsigned N = DLY - 1;
    localparam int unsigned W = 1 + BEN_W + DAT_W + 1;

    logic [W-1:0] pipe [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {req_trn, req_ren, req_dat, req_err};
            for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {rsp_trn, rsp_ren, rsp_dat, rsp_err} = pipe[N-1];

endmodule

// File: rtl/tcb_lib_memory_sub.sv
// TCB subordinate RAM: byte-enabled writes, fixed-latency reads with
// per-group read-data hold, optional wait states and out-of-range status.
module tcb_lib_memory_sub
    import tcb_lib_pkg::*;
#(
    parameter  int unsigned ADR_W = 32,
    parameter  int unsigned DAT_W = 32,
    localparam int unsigned BEN_W = tcb_ben_w(DAT_W),
    parameter  int unsigned SIZE  = 4096,
    parameter  int unsigned DLY   = 1,
    parameter  int unsigned WAIT  = 0,
    parameter  int unsigned GRN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    output logic             rdy,
    input  logic             wen,
    input  logic [ADR_W-1:0] adr,
    input  logic [BEN_W-1:0] ben,
    input  logic [DAT_W-1:0] wdt,
    output logic [DAT_W-1:0] rdt,
    output logic             sts
);

    localparam int unsigned OFF_W = $clog2(BEN_W);
    localparam int unsigned IDX_W = $clog2(SIZE) - OFF_W;
    localparam int unsigned DEPTH = SIZE / BEN_W;
    localparam int unsigned GRP   = BEN_W / GRN;
    localparam logic [ADR_W:0] LIM = (ADR_W+1)'(SIZE);

    logic             trn;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    tcb_sts_t         err;
    logic [DAT_W-1:0] rd_dat;
    logic [BEN_W-1:0] rd_ren;

    logic             rsp_trn;
    logic [BEN_W-1:0] rsp_ren;
    logic [DAT_W-1:0] rsp_dat;
    logic             rsp_err;

    logic [DAT_W-1:0] mem [DEPTH];

    assign trn      = vld & rdy;
    assign in_range = {1'b0, adr} < LIM;
    assign idx      = adr[OFF_W+IDX_W-1:OFF_W];
    assign err      = in_range ? TCB_OK : TCB_ERR;
    assign rd_dat   = in_range ? mem[idx] : '0;
    assign rd_ren   = trn ? (ben & {BEN_W{~wen}}) : '0;

    always_ff @(posedge clk) begin
        if (trn & wen & in_range) begin
            for (int b = 0; b < BEN_W; b++)
                if (ben[b]) mem[idx][8*b +: 8] <= wdt[8*b +: 8];
        end
    end

    generate
        if (DLY > 1) begin : g_dly
            tcb_lib_memory_delay #(
                .DLY   (DLY),
                .DAT_W (DAT_W),
                .BEN_W (BEN_W)
            ) u_delay (
                .clk     (clk),
                .rst     (rst),
                .req_trn (trn),
                .req_ren (rd_ren),
                .req_dat (rd_dat),
                .req_err (err),
                .rsp_trn (rsp_trn),
                .rsp_ren (rsp_ren),
                .rsp_dat (rsp_dat),
                .rsp_err (rsp_err)
            );
        end else begin : g_nodly
            assign rsp_trn = trn;
            assign rsp_ren = rd_ren;
            assign rsp_dat = rd_dat;
            assign rsp_err = err;
        end
    endgenerate

    // Unread groups keep their previous contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdt <= '0;
            sts <= 1'b0;
        end else begin
            if (rsp_trn) sts <= rsp_err;
            for (int g = 0; g < GRP; g++)
                if (rsp_ren[g*GRN])
                    rdt[g*GRN*8 +: GRN*8] <= rsp_dat[g*GRN*8 +: GRN*8];
        end
    end

    generate
        if (WAIT == 0) begin : g_nowait
            assign rdy = 1'b1;
        end else begin : g_wait
            localparam logic [2:0] CNT_END = 3'(WAIT - 1);

            tcb_mem_st_t st, st_nxt;
            logic [2:0]  cnt, cnt_nxt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    st  <= ST_IDLE;
                    cnt <= '0;
                end else begin
                    st  <= st_nxt;
                    cnt <= cnt_nxt;
                end
            end

            always_comb begin
                st_nxt  = st;
                cnt_nxt = cnt;
                unique case (st)
                    ST_IDLE: begin
                        if (vld) st_nxt = ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (!vld) begin
                            st_nxt  = ST_IDLE;
                            cnt_nxt = '0;
                        end else if (cnt == CNT_END) begin
                            st_nxt  = ST_READY;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + 3'd1;
                        end
                    end
                    ST_READY: begin
                        if (vld) st_nxt = ST_WAIT;
                    end
                    default: st_nxt = ST_IDLE;
                endcase
            end

            assign rdy = (st == ST_READY);
        end
    endgenerate

endmodule

// File: tb/tb_tcb_lib_memory_sub.sv
// Bench for tcb_lib_memory_sub: three configurations (DLY1/WAIT0,
// DLY3/WAIT0, DLY1/WAIT3) checked against a scoreboard of expected responses.
module tb_tcb_lib_memory_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        vld [3];
    logic        rdy [3];
    logic        wen [3];
    logic        sts [3];
    logic [31:0] adr [3];
    logic [31:0] wdt [3];
    logic [31:0] rdt [3];
    logic [3:0]  ben [3];

    tcb_lib_memory_sub #(.DLY(1), .WAIT(0)) u_d1 (
        .clk(clk), .rst(rst), .vld(vld[0]), .rdy(rdy[0]), .wen(wen[0]),
        .adr(adr[0]), .ben(ben[0]), .wdt(wdt[0]), .rdt(rdt[0]), .sts(sts[0])
    );

    tcb_lib_memory_sub #(.DLY(3), .WAIT(0)) u_d3 (
        .clk(clk), .rst(rst), .vld(vld[1]), .rdy(rdy[1]), .wen(wen[1]),
        .adr(adr[1]), .ben(ben[1]), .wdt(wdt[1]), .rdt(rdt[1]), .sts(sts[1])
    );

    tcb_lib_memory_sub #(.DLY(1), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst), .vld(vld[2]), .rdy(rdy[2]), .wen(wen[2]),
        .adr(adr[2]), .ben(ben[2]), .wdt(wdt[2]), .rdt(rdt[2]), .sts(sts[2])
    );

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] rdt;
        logic        sts;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem_m [3][1024];
    logic [31:0] rdt_m [3];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          t0, t1, s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int dly_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due == cyc) begin
                check($sformatf("rdt%0d@%0d", sb[k].inst, cyc),
                      rdt[sb[k].inst], sb[k].rdt);
                check($sformatf("sts%0d@%0d", sb[k].inst, cyc),
                      32'(sts[sb[k].inst]), 32'(sb[k].sts));
                sb.delete(k);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic xfer(input int i, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output int tc);
        int          n;
        logic        in_rng;
        logic [31:0] m;
        n = 0;
        vld[i] = 1'b1;
        wen[i] = w;
        adr[i] = a;
        ben[i] = b;
        wdt[i] = d;
        while (!rdy[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        tc = cyc;
        if (!rdy[i]) begin
            check($sformatf("rdy_timeout%0d", i), 32'(rdy[i]), 32'd1);
            vld[i] = 1'b0;
            return;
        end
        in_rng = (a < 32'h1000);
        m = in_rng ? mem_m[i][a[11:2]] : 32'd0;
        if (w) begin
            if (in_rng)
                for (int k = 0; k < 4; k++)
                    if (b[k]) mem_m[i][a[11:2]][8*k +: 8] = d[8*k +: 8];
        end else begin
            for (int k = 0; k < 4; k++)
                if (b[k]) rdt_m[i][8*k +: 8] = m[8*k +: 8];
        end
        sb.push_back('{i, cyc + dly_of(i), rdt_m[i], !in_rng});
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            vld[i]   = 1'b0;
            wen[i]   = 1'b0;
            adr[i]   = '0;
            ben[i]   = '0;
            wdt[i]   = '0;
            rdt_m[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy0", 32'(rdy[0]), 32'd1);
        check("rst_rdy2", 32'(rdy[2]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_rdt%0d", i), rdt[i], 32'd0);
            check($sformatf("rst_sts%0d", i), 32'(sts[i]), 32'd0);
        end

        // DLY=1, WAIT=0: full/partial writes, byte-hold reads, range checks
        xfer(0, 1'b1, 32'h10,   4'hF,    32'hDEADBEEF, t0);
        xfer(0, 1'b0, 32'h10,   4'hF,    32'h0,        t0);
        xfer(0, 1'b1, 32'h10,   4'b0010, 32'h0000AA00, t0);
        xfer(0, 1'b0, 32'h10,   4'hF,    32'h0,        t0);
        xfer(0, 1'b1, 32'h20,   4'hF,    32'h11223344, t0);
        xfer(0, 1'b0, 32'h20,   4'hF,    32'h0,        t0);
        xfer(0, 1'b0, 32'h13,   4'b0001, 32'h0,        t0);
        xfer(0, 1'b0, 32'h10,   4'b0100, 32'h0,        t0);
        xfer(0, 1'b1, 32'h0,    4'hF,    32'hCAFEF00D, t0);
        xfer(0, 1'b0, 32'h1000, 4'hF,    32'h0,        t0);
        xfer(0, 1'b1, 32'h1000, 4'hF,    32'h5A5A5A5A, t0);
        xfer(0, 1'b0, 32'h0,    4'hF,    32'h0,        t0);
        xfer(0, 1'b1, 32'h30,   4'hF,    32'h55667788, t0);
        xfer(0, 1'b0, 32'h30,   4'hF,    32'h0,        t0);
        vld[0] = 1'b0;

        // DLY=3: back-to-back writes then back-to-back reads
        for (int k = 0; k < 4; k++)
            xfer(1, 1'b1, 32'(4*k), 4'hF, 32'h10203040 * (k + 1) + k, t0);
        for (int k = 0; k < 4; k++)
            xfer(1, 1'b0, 32'(4*k), 4'hF, 32'h0, t0);
        vld[1] = 1'b0;
        repeat (4) @(negedge clk);

        // Reset two cycles after a DLY=3 read: pending response must vanish
        xfer(1, 1'b0, 32'h4, 4'hF, 32'h0, t0);
        vld[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) rdt_m[i] = '0;
        #1;
        check("rstmid_rdt", rdt[1], 32'd0);
        check("rstmid_sts", 32'(sts[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_rdt%0d", k), rdt[1], 32'd0);
        end
        xfer(1, 1'b0, 32'h4, 4'hF, 32'h0, t0);
        vld[1] = 1'b0;

        // WAIT=3: first transfer from idle, then one every 4th cycle
        s = cyc;
        xfer(2, 1'b1, 32'h8, 4'hF, 32'h89ABCDEF, t0);
        check("wait_first", 32'(t0 - s), 32'd4);
        xfer(2, 1'b0, 32'h8, 4'hF, 32'h0, t1);
        check("wait_gap1", 32'(t1 - t0), 32'd4);
        xfer(2, 1'b0, 32'h8, 4'b0011, 32'h0, t0);
        check("wait_gap2", 32'(t0 - t1), 32'd4);
        vld[2] = 1'b0;
        repeat (2) @(negedge clk);

        // vld dropped during the count: no transfer, count restarts
        vld[2] = 1'b1;
        wen[2] = 1'b0;
        adr[2] = 32'h8;
        ben[2] = 4'hF;
        repeat (2) @(negedge clk);
        check("wait_nordy", 32'(rdy[2]), 32'd0);
        vld[2] = 1'b0;
        @(negedge clk);
        check("wait_drop_rdy", 32'(rdy[2]), 32'd0);
        s = cyc;
        xfer(2, 1'b0, 32'h8, 4'hF, 32'h0, t0);
        check("wait_restart", 32'(t0 - s), 32'd4);
        vld[2] = 1'b0;

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
